// File: rtl/arb_pkg.sv
// Shared constants and state type for the four-requester round-robin arbiter.
package arb_pkg;
  localparam int unsigned NUM_REQ            = 4;
  localparam int unsigned IDX_W              = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arbiter4_dec2x4.sv
// Combinational 2-to-4 decoder with enable; expands the owner index into a one-hot grant.
module dec2x4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) dec_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold until release.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             force_rel;

  // First set request scanning upward from ptr, wrapping modulo 4.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + i[IDX_W-1:0];
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  assign force_rel = (state_q == ST_GRANT) && req[idx_q] && (cnt_q == HOLD_LAST);

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (force_rel) begin
      timeout_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign force_rel  = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          idx_d   = winner;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[idx_q] || force_rel) begin
          ptr_d   = idx_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  dec2x4 u_dec (
    .idx_i (idx_q),
    .en_i  (state_q == ST_GRANT),
    .dec_o (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt;

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter for a shared single-owner resource. Selects one requester, holds the grant until that requester releases it, then rotates priority. The winning 2-bit index is expanded to a one-hot grant vector by a 2-to-4 decoder sub-module. Sits between the requesting units and the shared resource, typically a bus, register port or memory.

## Interface
- TIMEOUT_CYCLES, default 8: maximum grant hold in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  [3:0]  request per requester; level-sensitive; held high while the resource is wanted.
- gnt  output  [3:0]  one-hot grant, registered; all zero when no owner.
- gnt_idx  output  [1:0]  binary index of current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  a grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout; constant 0 when ARB_TIMEOUT_EN is not defined.

## Operation
- State machine with two states, IDLE and GRANT; state, pointer and grant index are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit of req, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load gnt_idx with the winner and go to GRANT.
- GRANT:
  - Stay while req[gnt_idx]=1. Requests from other requesters are ignored; there is no preemption.
  - When req[gnt_idx]=0, go to IDLE and set ptr = gnt_idx+1 (mod 4; 3 wraps to 0).
- gnt = dec2x4(gnt_idx) gated by (state==GRANT). At most one bit of gnt is ever set.
- Fairness: a requester that holds req continuously is granted within 3 intervening grants.
- Reset (rst_n=0 at a clock edge), including mid-grant:
  - state=IDLE, ptr=0, gnt_idx=0.
  - gnt=0000, gnt_valid=0, timeout=0.
  - timeout counter=0.

## Timing
- req rising in cycle t with the arbiter idle: gnt is visible at t+1 (1-cycle latency).
- Owner deasserts req in cycle t: gnt=0000 at t+1. The earliest next grant is at t+2, so there is always exactly one dead cycle between owners.
- Simultaneous requests in IDLE: the winner is resolved by the ptr ordering in the same cycle.
- Owner drops req while others rise in the same cycle: release first, then arbitrate from the new ptr in the following IDLE cycle.
- req pulse of one cycle during IDLE: grant issued at t+1, released at t+2 because req is already low.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter clears on entry to GRANT and increments on each GRANT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with req[gnt_idx] still high, the arbiter forces release: go to IDLE, ptr = gnt_idx+1, and pulse timeout for 1 cycle coincident with gnt dropping.
  - The revoked requester competes again at lowest priority.
- ARB_TIMEOUT_EN not defined:
  - No counter is built and grants are held indefinitely.
  - timeout is tied to 0.

## Structure
- Shared package arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_GRANT=1'b1;
  - NUM_REQ=4;
  - IDX_W=2;
  - default TIMEOUT_CYCLES.
- One sub-module, dec2x4: combinational 2-to-4 decoder with enable, producing gnt from gnt_idx and (state==GRANT).
- Round-robin select is a small combinational priority rotate inside rr_arbiter4; the timeout counter sits under the ARB_TIMEOUT_EN guard.

## Test plan
- Reset, then req=0000 for 5 cycles -> gnt=0000, gnt_valid=0, timeout=0 throughout.
- req=0100 from cycle 3 -> gnt=0100 and gnt_idx=2 at cycle 4; req drops at cycle 8 -> gnt=0000 at 9, and ptr=3 is visible by the next grant order.
- req=1111 held; each owner drops req for 1 cycle after 2 grant cycles -> grant order 0,1,2,3,0 with one dead cycle between grants.
- Owner 1 holds, req=1111 -> gnt stays 0010 for 20 cycles without ARB_TIMEOUT_EN. With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, gnt drops after 8 grant cycles with timeout=1 for one cycle, and the next grant goes to 2.
- rst_n=0 for one edge while gnt=1000 -> gnt=0000 next cycle; with req=1111 the next grant goes to 0 (ptr=0).
- ptr=3 with req=1001 in IDLE -> grant goes to 3; after release, req=1001 -> grant goes to 0 (wrap-around).
